// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types for the APB requester arbiter.
// Holds the FSM states, the latched command bundle and width defaults.
package apb_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  // Index wide enough for up to 8 requesters.
  localparam int IDX_W = 3;

  // The command bundle is sized for the widest supported bus; the top
  // narrows it back to ADDR_W/DATA_W on the way out.
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [IDX_W-1:0]  idx;
  } cmd_t;

endpackage

// File: rtl/apb_req_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting after last_grant.
// Ports: req (request vector), last_grant -> grant (one-hot), idx.
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic               found;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] req_sh;

  // Walk last+1, last+2, ... last+NUM_REQ (mod NUM_REQ);
  // the first pending request found wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    req_sh = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand   = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        grant = NUM_REQ'(1) << cand;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin share of one APB bridge by NUM_REQ users.
// Ports: PCLK/PRESETn, req_* in, req_ready/rsp_* out, bridge-side APB.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         apb_read_data_out
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  cmd_t       cmd_q, cmd_d;

  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               apb_done;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .last_grant(last_q),
    .grant     (pick_grant),
    .idx       (pick_idx)
  );

  // Mux the winner's fields via its one-hot grant.
  assign sel_write = |(req_write & pick_grant);

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign apb_done = PENABLE && PREADY;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      // write=1 keeps READ_WRITE low until a real command lands.
      cmd_q   <= '{write: 1'b1, default: '0};
      last_q  <= IDX_W'(NUM_REQ - 1);
      wdog_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready   = pick_grant;
          cmd_d.write = sel_write;
          cmd_d.addr  = CMD_AW'(sel_addr);
          cmd_d.wdata = CMD_DW'(sel_wdata);
          cmd_d.idx   = pick_idx;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        wdog_d  = '0;
        state_d = XFER;
      end
      XFER: begin
        // Completion beats a same-cycle timeout.
        if (apb_done) begin
          rdata_d = cmd_q.write ? '0 : apb_read_data_out;
          err_d   = PSLVERR;
          state_d = RESP;
        end else if (PSLVERR || wdog_q == WD_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << cmd_q.idx;
        last_d    = cmd_q.idx;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drops in the completion cycle so the bridge goes ENABLE -> IDLE.
  assign transfer = (state_q == XFER) && !apb_done && !PSLVERR;

  assign rsp_rdata  = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err    = (state_q == RESP) && err_q;
  assign READ_WRITE = ~cmd_q.write;

  assign apb_write_paddr = ADDR_W'(cmd_q.addr);
  assign apb_read_paddr  = ADDR_W'(cmd_q.addr);
  assign apb_write_data  = cmd_q.write ? DATA_W'(cmd_q.wdata) : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: bench with APB bridge/slave model and
// timeline reference model for apb_req_arbiter.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, transfer, READ_WRITE;
  logic [AW-1:0]   apb_write_paddr, apb_read_paddr;
  logic [DW-1:0]   apb_write_data;
  logic            PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]   apb_read_data_out;

  apb_req_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .apb_read_data_out(apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave contents: a fixed function of the address.
  function automatic logic [7:0] sdata(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'h80 : 8'h00) ^ 8'hB9;
  endfunction

  // Bridge + slave. A cycle with transfer high and no ENABLE is SETUP.
  // Modes: 0 ok, 1 PSLVERR with PREADY, 2 early PSLVERR, 3 stall.
  logic b_en;
  int   s_wait, s_mode;
  bit   d_on = 1'b1;
  int   d_mode = 0;
  int   d_wait = 0;
  int   r;

  assign PENABLE = b_en;
  assign PREADY  = b_en && (s_mode < 2) && (s_wait == 0);
  assign PSLVERR = b_en && ((s_mode == 1 && s_wait == 0) || s_mode == 2);
  assign apb_read_data_out = sdata(apb_read_paddr);

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      b_en   <= 1'b0;
      s_wait <= 0;
      s_mode <= 0;
    end else if (b_en) begin
      if (PREADY || !transfer) b_en <= 1'b0;
      else if (s_wait > 0) s_wait <= s_wait - 1;
    end else if (transfer) begin
      b_en <= 1'b1;
      if (d_on) begin
        s_mode <= d_mode;
        s_wait <= d_wait;
      end else begin
        r = int'($urandom % 32);
        s_mode <= (r == 0) ? 3 : (r == 1) ? 2 : (r < 5) ? 1 : 0;
        s_wait <= int'($urandom % 4);
      end
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Reference model: a command granted in cycle g occupies g+1 (setup
  // of the bus side), bus activity from g+2 until an end cycle, and
  // answers in the cycle after the end.
  int cyc = 0;
  int rsp_cnt = 0;
  bit m_busy, m_have, m_w, m_err, in_x, in_r, e_tr;
  int m_g, m_end, m_last, m_idx, w, n;
  logic [8:0] m_a;
  logic [7:0] m_d, m_rdata;
  logic [N-1:0] e_rdy, e_rsp;
  logic [N-1:0] obs_ready = '0;

  int t_ready_cyc, t_rsp_cyc, t_xfer_n, t_act_n, t_idx;
  logic [8:0] t_addr;
  logic [7:0] t_rdata;
  bit t_err;
  int gq[$];

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      m_busy = 1'b0;
      m_have = 1'b0;
      m_last = N - 1;
      m_end = -1;
      cyc = 0;
      obs_ready = '0;
    end else begin
      cyc++;
      in_x = m_busy && cyc >= m_g + 2 && m_end < 0;
      in_r = m_busy && m_end >= 0 && cyc == m_end + 1;
      w = -1;
      e_rdy = '0;
      if (!m_busy && req_valid != '0) begin
        w = rr_pick(m_last, req_valid);
        e_rdy = N'(1) << w;
      end
      e_tr = in_x && !(PENABLE && PREADY) && !PSLVERR;
      e_rsp = in_r ? (N'(1) << m_idx) : '0;
      chk("req_ready", req_ready, e_rdy);
      chk("transfer", transfer, e_tr);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("rsp_rdata", rsp_rdata, in_r ? m_rdata : 8'h00);
      chk("rsp_err", rsp_err, in_r && m_err);
      chk("read_write", READ_WRITE, m_have && !m_w);
      chk("write_paddr", apb_write_paddr, m_have ? m_a : 9'h0);
      chk("read_paddr", apb_read_paddr, m_have ? m_a : 9'h0);
      chk("write_data", apb_write_data, (m_have && m_w) ? m_d : 8'h0);

      obs_ready = req_ready;
      if (req_ready != '0) begin
        t_ready_cyc = cyc;
        t_xfer_n = 0;
        t_act_n = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
      end
      if (transfer) begin
        t_xfer_n++;
        t_addr = apb_write_paddr;
      end
      if (transfer || PENABLE) t_act_n++;
      if (rsp_valid != '0) begin
        rsp_cnt++;
        t_rsp_cyc = cyc;
        t_rdata = rsp_rdata;
        t_err = rsp_err;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) t_idx = i;
      end

      if (in_x) begin
        n = cyc - (m_g + 2);
        if (PENABLE && PREADY) begin
          m_end = cyc;
          m_err = PSLVERR;
          m_rdata = m_w ? 8'h00 : sdata(m_a);
        end else if (PSLVERR || n == TO - 1) begin
          m_end = cyc;
          m_err = 1'b1;
          m_rdata = 8'h00;
        end
      end
      if (in_r) begin
        m_busy = 1'b0;
        m_last = m_idx;
      end
      if (w >= 0) begin
        m_busy = 1'b1;
        m_have = 1'b1;
        m_g = cyc;
        m_end = -1;
        m_idx = w;
        m_w = req_write[w];
        m_a = req_addr[w*AW +: AW];
        m_d = req_wdata[w*DW +: DW];
      end
    end
  end

  task automatic set_req(input int i, input bit wr, input logic [8:0] a,
                         input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 1'($urandom % 2), 9'($urandom % 512), 8'($urandom % 256));
  endtask

  task automatic wait_rsp(input int tgt, input int lim);
    int k = 0;
    while (rsp_cnt < tgt && k < lim) begin
      @(posedge PCLK);
      k++;
    end
    if (rsp_cnt < tgt) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_wait: got %0d responses expected %0d", rsp_cnt, tgt);
    end
    #1;
  endtask

  task automatic one_req(input int i, input bit wr, input logic [8:0] a,
                         input logic [7:0] d, input int dm, input int dwt);
    int base = rsp_cnt;
    int k = 0;
    d_mode = dm;
    d_wait = dwt;
    @(posedge PCLK);
    #1;
    set_req(i, wr, a, d);
    while (!obs_ready[i] && k < 40) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    chk("ready_seen", obs_ready[i], 1'b1);
    req_valid[i] = 1'b0;
    wait_rsp(base + 1, 60);
  endtask

  int base, k;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_ctl", {req_ready, rsp_valid, rsp_err, transfer, READ_WRITE}, 0);
    chk("reset_bus", {apb_write_paddr, apb_read_paddr, apb_write_data, rsp_rdata}, 0);
    PRESETn = 1'b1;

    // Zero-wait write by requester 0.
    one_req(0, 1'b1, 9'h005, 8'hA5, 0, 0);
    chk("t1_latency", t_rsp_cyc - t_ready_cyc + 1, 5);
    chk("t1_xfer_cycles", t_act_n, 2);
    chk("t1_psel1", t_addr[8], 1'b0);
    chk("t1_err", t_err, 1'b0);
    chk("t1_idx", t_idx, 0);

    // Read by requester 2 with two wait states.
    one_req(2, 1'b0, 9'h105, 8'h00, 0, 2);
    chk("t2_latency", t_rsp_cyc - t_ready_cyc + 1, 7);
    chk("t2_rdata", t_rdata, 8'h3C);
    chk("t2_psel2", t_addr[8], 1'b1);
    chk("t2_err", t_err, 1'b0);

    // Stalled slave: watchdog abort by requester 3.
    one_req(3, 1'b0, 9'h0AA, 8'h00, 3, 0);
    chk("to_transfer_cycles", t_xfer_n, 16);
    chk("to_latency", t_rsp_cyc - t_ready_cyc + 1, 19);
    chk("to_err", t_err, 1'b1);
    chk("to_rdata", t_rdata, 8'h00);

    // All four held valid for eight grants.
    d_mode = 0;
    d_wait = 1;
    gq.delete();
    base = rsp_cnt;
    @(posedge PCLK);
    #1;
    for (int i = 0; i < N; i++) set_rand(i);
    k = 0;
    while (gq.size() < 8 && k < 300) begin
      @(posedge PCLK);
      #1;
      k++;
      for (int i = 0; i < N; i++)
        if (obs_ready[i]) begin
          if (gq.size() >= 8) req_valid[i] = 1'b0;
          else set_rand(i);
        end
    end
    req_valid = '0;
    chk("rr_grants", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) begin
      chk($sformatf("rr_order%0d", i), gq[i], i % 4);
      if (i > 0) chk($sformatf("rr_norepeat%0d", i), gq[i] != gq[i-1], 1);
    end
    wait_rsp(base + 8, 400);

    // PSLVERR in ENABLE on a write, then a normal read.
    one_req(1, 1'b1, 9'h0C3, 8'h11, 1, 0);
    chk("se_err", t_err, 1'b1);
    chk("se_idx", t_idx, 1);
    one_req(2, 1'b0, 9'h033, 8'h00, 0, 1);
    chk("se_next_err", t_err, 1'b0);
    chk("se_next_rdata", t_rdata, 8'h8A);
    chk("se_next_idx", t_idx, 2);

    // Reset in the middle of a transfer.
    d_mode = 0;
    d_wait = 3;
    @(posedge PCLK);
    #1;
    set_req(3, 1'b0, 9'h0F0, 8'h00);
    k = 0;
    while (!transfer && k < 20) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    chk("rst_in_xfer", transfer, 1'b1);
    req_valid = '0;
    base = rsp_cnt;
    #1 PRESETn = 1'b0;
    #1;
    chk("rst_mid_ctl", {req_ready, rsp_valid, rsp_err, transfer, READ_WRITE}, 0);
    chk("rst_mid_bus", {apb_write_paddr, apb_read_paddr, apb_write_data, rsp_rdata}, 0);
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    set_req(0, 1'b1, 9'h011, 8'h22);
    set_req(1, 1'b1, 9'h012, 8'h33);
    set_req(3, 1'b1, 9'h013, 8'h44);
    k = 0;
    while (obs_ready == '0 && k < 20) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    chk("rst_first_grant", obs_ready, 4'b0001);
    chk("rst_no_rsp", rsp_cnt, base);
    req_valid = '0;
    wait_rsp(base + 1, 60);

    // Randomized traffic with a randomized slave.
    d_on = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge PCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (obs_ready[i]) begin
          if ($urandom % 2 == 0) set_rand(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom % 6 == 0) begin
          set_rand(i);
        end
      end
    end
    req_valid = '0;
    repeat (40) @(posedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
